aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Controller for an iterative AES-128 encryption datapath. It accepts plaintext and key on a valid/ready handshake.
- It performs the initial AddRoundKey itself, then sequences NR rounds through an external single-round datapath and single-step key expander, one round per cycle.
- It presents ciphertext on a valid/ready output handshake.
- It sits between the stimulus/host side and the combinational round logic of Top_level, replacing free-running operation with a controlled, stallable pipeline of one block in flight.

Parameters:
- NR, 10, number of AES rounds; the final round is flagged with dp_last. Legal range 1..15.
- DW, 128, block and key width in bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  plaintext/key offered.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  DW  plaintext.
- in_key  input  DW  cipher key.
- flush  input  1  synchronous abort; returns to IDLE.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_data  output  DW  ciphertext, equal to the internal state register.
- busy  output  1  high in ROUND or DONE.
- dp_state  output  DW  current state to the round datapath.
- dp_key  output  DW  current round key to the key expander.
- dp_round  output  4  round index 1..NR, drives Rcon selection.
- dp_last  output  1  high when dp_round==NR; omit MixColumns.
- dp_next_key  input  DW  expanded key for round dp_round (combinational from dp_key, dp_round).
- dp_next_state  input  DW  round output (combinational from dp_state, dp_next_key, dp_last).

Behaviour:
- Reset (async, rst_n low):
  - FSM = IDLE; state_reg, key_reg = 0; rnd = 0.
  - in_ready = 1 after reset release; out_valid = 0; busy = 0.
  - dp_round = 0, dp_last = 0.
- FSM has three states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: state_reg <= in_data ^ in_key; key_reg <= in_key; rnd <= 1; go to ROUND.
- ROUND:
  - dp_state = state_reg, dp_key = key_reg, dp_round = rnd, dp_last = (rnd==NR).
  - Each cycle: state_reg <= dp_next_state; key_reg <= dp_next_key.
  - If rnd==NR, go to DONE; else rnd <= rnd+1.
- DONE:
  - out_valid = 1; out_data = state_reg, held stable while out_ready is low.
  - On out_ready: go to IDLE and clear rnd to 0.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept.
- Latency: accept at edge T. Rounds are registered at edges T+1..T+NR. out_valid is high from edge T+NR onward. Minimum throughput is one block per NR+2 cycles.
- dp_round and dp_last are forced to 0 outside ROUND. dp_state and dp_key always mirror their registers.
- flush:
  - Takes priority over all other transitions in every state.
  - Next state is IDLE; rnd <= 0; out_valid drops the next cycle.
  - state_reg and key_reg are left unchanged, since they are don't-care in IDLE.
- Simultaneous events:
  - flush together with in_valid in IDLE: flush wins; the block is not accepted.
  - flush together with out_ready in DONE: both lead to IDLE; the transfer counts as consumed.
- in_data and in_key are sampled only on the accept edge. Later changes while busy are ignored.
- rnd is 4 bits and cannot wrap, because NR≤15.
- Reset asserted mid-operation discards the block immediately. No partial output is produced.

Decomposition:
- Shared package aes_pkg holds:
  - localparams AES_NR_128=10 and AES_DW=128;
  - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2);
  - the FIPS-197 test constants used by the bench.
- No sub-module. The FSM, round counter and two DW-bit registers live in one module.
- Round and key-step logic stay external as aes_round and aes_key_step.

Test Plan:
- Stub datapath (dp_next_state = dp_state+1, dp_next_key = dp_key), in_data = in_key = 128'h5 -> out_valid exactly 10 cycles after accept; out_data = 128'h0a; dp_round observed 1..10; dp_last high only at round 10.
- Real aes_round and aes_key_step; key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734 -> out_data = 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready held low for 5 cycles in DONE -> out_valid and out_data stable, in_ready = 0, new in_valid not accepted; block consumed on the first out_ready cycle.
- flush asserted at round 4 -> IDLE next cycle, out_valid never rises, in_ready = 1. Next block encrypts correctly (FIPS vector again).
- rst_n pulsed low asynchronously mid-round (between edges) -> outputs return to reset values immediately without waiting for clk; first block after release is correct.
- Back-to-back blocks with in_valid and out_ready held high -> accepts spaced exactly NR+2 = 12 cycles apart; both ciphertexts correct.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, FSM encoding and FIPS-197 reference vectors for the AES round sequencer
package aes_pkg;
   localparam int AES_NR_128 = 10;
   localparam int AES_DW     = 128;
   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} seq_state_t;
   localparam logic [127:0] FIPS_B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] FIPS_C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
endpackage

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: one-block-in-flight controller for an iterative AES-128 datapath
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready/in_data/in_key : plaintext and key handshake (accepted only in IDLE)
//   flush                      : synchronous abort back to IDLE
//   out_valid/out_ready/out_data: ciphertext handshake
//   busy                       : block in flight (ROUND or DONE)
//   dp_state/dp_key/dp_round/dp_last : drive the external round and key-step logic
//   dp_next_state/dp_next_key  : combinational results returned by that logic
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR = AES_NR_128,
   parameter int DW = AES_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic [DW-1:0] in_key,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy,
   output logic [DW-1:0] dp_state,
   output logic [DW-1:0] dp_key,
   output logic [3:0]    dp_round,
   output logic          dp_last,
   input  logic [DW-1:0] dp_next_key,
   input  logic [DW-1:0] dp_next_state
);
   seq_state_t    fsm;
   logic [DW-1:0] state_reg, key_reg;
   logic [3:0]    rnd;
   logic          in_round;

   assign in_round = (fsm == ROUND);
   assign dp_state = state_reg;
   assign dp_key   = key_reg;
   assign out_data = state_reg;
   // rnd lingers at NR through DONE, so the round outputs are gated to ROUND
   assign dp_round = in_round ? rnd : 4'd0;
   assign dp_last  = in_round && (rnd == 4'(NR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= IDLE;
         state_reg <= '0;
         key_reg   <= '0;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (flush) begin
         fsm       <= IDLE;
         rnd       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state_reg <= in_data ^ in_key;
               key_reg   <= in_key;
               rnd       <= 4'd1;
               fsm       <= ROUND;
               in_ready  <= 1'b0;
               busy      <= 1'b1;
            end
            ROUND: begin
               state_reg <= dp_next_state;
               key_reg   <= dp_next_key;
               if (rnd == 4'(NR)) begin
                  fsm       <= DONE;
                  out_valid <= 1'b1;
               end else
                  rnd <= rnd + 4'd1;
            end
            DONE: if (out_ready) begin
               fsm       <= IDLE;
               rnd       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: begin
               fsm       <= IDLE;
               rnd       <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed self-checking bench with a stub and a reference AES round model
module tb_aes_round_sequencer;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [127:0] in_data = '0, in_key = '0;
   logic         in_ready, out_valid, busy, dp_last;
   logic [127:0] out_data, dp_state, dp_key, dp_next_key, dp_next_state;
   logic [3:0]   dp_round;
   logic         use_real = 1'b0;
   int           tests = 0, fails = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // multiplicative inverse as a^254, then the affine transform
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] s, r;
      s = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gmul(s, s);
         r = gmul(r, s);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int i = 0; i < 16; i++) t[i] = a[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
      if (!last)
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
      return res ^ k;
   endfunction

   function automatic logic [127:0] ref_key_step(input logic [127:0] k, input logic [3:0] r);
      logic [7:0]  rc;
      logic [31:0] w3, t, n0, n1, n2, n3;
      rc = 8'h01;
      for (int j = 1; j < 16; j++) if (j < int'(r)) rc = xt(rc);
      w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   assign dp_next_key   = use_real ? ref_key_step(dp_key, dp_round) : dp_key;
   assign dp_next_state = use_real ? ref_round(dp_state, dp_next_key, dp_last) : dp_state + 128'd1;

   aes_round_sequencer #(.NR(10), .DW(128)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .dp_state(dp_state),
      .dp_key(dp_key), .dp_round(dp_round), .dp_last(dp_last),
      .dp_next_key(dp_next_key), .dp_next_state(dp_next_state)
   );

   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      in_data  = pt;
      in_key   = k;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if ({in_ready, out_valid, busy, dp_last} !== 4'b1000 || dp_round !== 4'd0) begin
         fails++;
         $display("FAIL reset_ctrl: rdy/val/busy/last=%b round=%0d, required 1000 round=0", {in_ready, out_valid, busy, dp_last}, dp_round);
      end
      tests++;
      if (out_data !== 128'h0 || dp_key !== 128'h0) begin
         fails++;
         $display("FAIL reset_regs: out_data=%h dp_key=%h, required 0", out_data, dp_key);
      end
   endtask

   task automatic test_stub;
      use_real = 1'b0;
      send(128'h5, 128'h5);
      for (int r = 1; r <= 10; r++) begin
         tests++;
         if (dp_round !== 4'(r) || dp_last !== 1'(r == 10) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stub_round%0d: round=%0d last=%b valid=%b rdy=%b, required round=%0d last=%b valid=0 rdy=0",
                     r, dp_round, dp_last, out_valid, in_ready, r, r == 10);
         end
         @(negedge clk);
      end
      tests++;
      if (out_valid !== 1'b1 || out_data !== 128'h0a || dp_round !== 4'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL stub_done: valid=%b data=%h round=%0d busy=%b, required valid=1 data=0a round=0 busy=1",
                  out_valid, out_data, dp_round, busy);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL stub_consume: valid=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_fips;
      use_real = 1'b1;
      send(FIPS_B_PT, FIPS_B_KEY);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== FIPS_B_CT) begin
         fails++;
         $display("FAIL fips_b: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, FIPS_B_CT);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      logic ok;
      send(FIPS_C_PT, FIPS_C_KEY);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data  = FIPS_B_PT;
         in_key   = FIPS_B_KEY;
         in_valid = 1'b1;
         if (out_valid !== 1'b1 || out_data !== FIPS_C_CT || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      tests++;
      if (!ok || out_data !== FIPS_C_CT || out_valid !== 1'b1) begin
         fails++;
         $display("FAIL backpressure_hold: valid=%b data=%h rdy=%b, required valid=1 data=%h rdy=0 for 5 cycles",
                  out_valid, out_data, in_ready, FIPS_C_CT);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL backpressure_consume: valid=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_flush;
      logic rose;
      send(FIPS_B_PT, FIPS_B_KEY);
      for (int i = 0; i < 10 && dp_round !== 4'd4; i++) @(negedge clk);
      tests++;
      if (dp_round !== 4'd4) begin
         fails++;
         $display("FAIL flush_reach_r4: round=%0d, required 4", dp_round);
      end
      flush    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || dp_round !== 4'd0) begin
         fails++;
         $display("FAIL flush_idle: rdy=%b busy=%b round=%0d, required 1 0 0", in_ready, busy, dp_round);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_beats_valid: busy=%b rdy=%b, required 0 1", busy, in_ready);
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      rose     = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid !== 1'b0) rose = 1'b1;
         @(negedge clk);
      end
      tests++;
      if (rose) begin
         fails++;
         $display("FAIL flush_no_output: out_valid rose=%b, required 0", rose);
      end
      send(FIPS_B_PT, FIPS_B_KEY);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== FIPS_B_CT) begin
         fails++;
         $display("FAIL flush_next_block: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, FIPS_B_CT);
      end
      flush = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_with_ready: valid=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_async_reset;
      send(FIPS_C_PT, FIPS_C_KEY);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({in_ready, out_valid, busy, dp_last} !== 4'b1000 || dp_round !== 4'd0 || out_data !== 128'h0) begin
         fails++;
         $display("FAIL async_reset: rdy/val/busy/last=%b round=%0d data=%h, required 1000 round=0 data=0",
                  {in_ready, out_valid, busy, dp_last}, dp_round, out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(FIPS_C_PT, FIPS_C_KEY);
      for (int i = 0; i < 30 && !out_valid; i++) @(negedge clk);
      tests++;
      if (out_valid !== 1'b1 || out_data !== FIPS_C_CT) begin
         fails++;
         $display("FAIL async_reset_next: valid=%b data=%h, required valid=1 data=%h", out_valid, out_data, FIPS_C_CT);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back;
      int           acc [2];
      logic [127:0] ct [2];
      int           n_acc, n_out;
      n_acc = 0;
      n_out = 0;
      acc[0] = 0; acc[1] = 0;
      ct[0] = '0; ct[1] = '0;
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (out_valid && n_out < 2) begin
            ct[n_out] = out_data;
            n_out++;
         end
         if (in_ready) begin
            if (n_acc < 2) begin
               in_data  = (n_acc == 0) ? FIPS_B_PT : FIPS_C_PT;
               in_key   = (n_acc == 0) ? FIPS_B_KEY : FIPS_C_KEY;
               in_valid = 1'b1;
               acc[n_acc] = c;
               n_acc++;
            end else
               in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tests++;
      if (n_acc !== 2 || acc[1] - acc[0] !== 12) begin
         fails++;
         $display("FAIL b2b_spacing: accepts=%0d spacing=%0d, required 2 accepts spaced 12", n_acc, acc[1] - acc[0]);
      end
      tests++;
      if (n_out !== 2 || ct[0] !== FIPS_B_CT || ct[1] !== FIPS_C_CT) begin
         fails++;
         $display("FAIL b2b_data: outputs=%0d ct0=%h ct1=%h, required 2 %h %h", n_out, ct[0], ct[1], FIPS_B_CT, FIPS_C_CT);
      end
   endtask

   initial begin
      test_reset();
      test_stub();
      test_fips();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
